// File: rtl/frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// frame_scheduler_if
//
// Purpose:
//   Bundles every non-clock signal of the frame scheduler: the frame tick from
//   the rate divider, the go/erase/done handshakes and pixel streams of the
//   bird and pipe drawers, the arbitrated VGA write port and the status outputs.
//
// Modports:
//   master - the scheduler side (drives step, *_go, *_erase, vga_*, status)
//   slave  - the environment side (drives frame_tick, *_done, drawer pixels)
//
// Signals:
//   frame_tick                    one-cycle frame pulse
//   step                          one-cycle game-state advance pulse
//   bird_go / pipe_go             one-cycle drawer start
//   bird_erase / pipe_erase       high for the whole of an erase phase
//   bird_done / pipe_done         drawer finished
//   bird_x/y/colour/plot          bird drawer pixel stream
//   pipe_x/y/colour/plot          pipe drawer pixel stream
//   vga_x/y/colour/plot           arbitrated VGA write port
//   busy                          high whenever the sequencer is not idle
//   missed_frames                 saturating count of dropped frame ticks
//   fault                         sticky phase-timeout flag
// -----------------------------------------------------------------------------
interface frame_scheduler_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
);
    logic           frame_tick;
    logic           step;

    logic           bird_go;
    logic           bird_erase;
    logic           bird_done;
    logic [X_W-1:0] bird_x;
    logic [Y_W-1:0] bird_y;
    logic [C_W-1:0] bird_colour;
    logic           bird_plot;

    logic           pipe_go;
    logic           pipe_erase;
    logic           pipe_done;
    logic [X_W-1:0] pipe_x;
    logic [Y_W-1:0] pipe_y;
    logic [C_W-1:0] pipe_colour;
    logic           pipe_plot;

    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;

    logic           busy;
    logic [7:0]     missed_frames;
    logic           fault;

    modport master (
        input  frame_tick,
        input  bird_done, bird_x, bird_y, bird_colour, bird_plot,
        input  pipe_done, pipe_x, pipe_y, pipe_colour, pipe_plot,
        output step,
        output bird_go, bird_erase,
        output pipe_go, pipe_erase,
        output vga_x, vga_y, vga_colour, vga_plot,
        output busy, missed_frames, fault
    );

    modport slave (
        output frame_tick,
        output bird_done, bird_x, bird_y, bird_colour, bird_plot,
        output pipe_done, pipe_x, pipe_y, pipe_colour, pipe_plot,
        input  step,
        input  bird_go, bird_erase,
        input  pipe_go, pipe_erase,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  busy, missed_frames, fault
    );
endinterface

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Purpose:
//   Per-frame sequencer and VGA write-port arbiter for the game screen. Each
//   frame tick runs: erase pipes, erase bird, step game state, draw pipes,
//   draw bird. Drawers are started with a one-cycle go and finish with done;
//   the active drawer's pixel stream is muxed onto the single VGA plot port.
//   A phase that never sees done is abandoned after TIMEOUT cycles and the
//   sticky fault flag is raised.
//
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   fs      frame_scheduler_if.master (tick, drawer handshakes/pixels,
//           VGA port, busy, missed_frames, fault)
//
// Parameters:
//   X_W, Y_W, C_W  pixel x / y / colour widths
//   ERASE_COLOUR   colour forced onto vga_colour during erase phases
//   TIMEOUT        maximum cycles a drawer phase waits for done (>= 2)
//
// Optional feature (macro FRAME_PEND_EN):
//   Defined   - a tick arriving while busy is held in a one-deep pending flag
//               and starts the next frame straight after returning to IDLE.
//   Undefined - every tick arriving while busy is counted as missed.
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int             X_W          = 8,
    parameter int             Y_W          = 7,
    parameter int             C_W          = 3,
    parameter logic [C_W-1:0] ERASE_COLOUR = '0,
    parameter int             TIMEOUT      = 20000
) (
    input logic               clk,
    input logic               resetn,
    frame_scheduler_if.master fs
);
    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_PIPE,
        S_ERASE_BIRD,
        S_STEP,
        S_DRAW_PIPE,
        S_DRAW_BIRD
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             step_q;
    logic             bird_go_q;
    logic             pipe_go_q;
    logic             bird_erase_q;
    logic             pipe_erase_q;
    logic             busy_q;
    logic [7:0]       missed_q;
    logic             fault_q;

    state_e           next_state_d;
    logic             phase_done_d;
    logic             drawer_phase_d;
    logic             done_ok_d;
    logic             timeout_d;
    logic             advance_d;
    logic             start_d;
    logic             count_miss_d;

`ifdef FRAME_PEND_EN
    logic             pend_q;
    logic             pend_d;
`endif

    // Frame start and missed-tick accounting.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        start_d      = 1'b0;
        count_miss_d = 1'b0;
`ifdef FRAME_PEND_EN
        pend_d       = pend_q;
        if (state_q == S_IDLE) begin
            // A held tick starts the frame now; a fresh tick on top of it is lost.
            start_d      = fs.frame_tick || pend_q;
            count_miss_d = fs.frame_tick && pend_q;
            pend_d       = 1'b0;
        end else if (fs.frame_tick) begin
            if (pend_q) begin
                count_miss_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
`else
        start_d      = fs.frame_tick && (state_q == S_IDLE);
        count_miss_d = fs.frame_tick && (state_q != S_IDLE);
`endif
    end

    // Phase successor and which drawer's done belongs to the current phase.
    always_comb begin
        phase_done_d = 1'b0;
        next_state_d = S_IDLE;
        case (state_q)
            S_IDLE:       next_state_d = S_ERASE_PIPE;
            S_ERASE_PIPE: begin
                phase_done_d = fs.pipe_done;
                next_state_d = S_ERASE_BIRD;
            end
            S_ERASE_BIRD: begin
                phase_done_d = fs.bird_done;
                next_state_d = S_STEP;
            end
            S_STEP:       next_state_d = S_DRAW_PIPE;
            S_DRAW_PIPE:  begin
                phase_done_d = fs.pipe_done;
                next_state_d = S_DRAW_BIRD;
            end
            S_DRAW_BIRD:  begin
                phase_done_d = fs.bird_done;
                next_state_d = S_IDLE;
            end
            default:      next_state_d = S_IDLE;
        endcase
    end

    assign drawer_phase_d = (state_q == S_ERASE_PIPE) || (state_q == S_ERASE_BIRD) ||
                            (state_q == S_DRAW_PIPE)  || (state_q == S_DRAW_BIRD);
    // cnt_q is zero only in the go cycle, so a done seen there is ignored.
    assign done_ok_d      = phase_done_d && (cnt_q != '0);
    assign timeout_d      = drawer_phase_d && (cnt_q == CNT_LAST) && !done_ok_d;
    // Illegal encodings fall through to the last arm and recover to IDLE.
    assign advance_d      = (state_q == S_IDLE) ? start_d :
                            drawer_phase_d      ? (done_ok_d || timeout_d) :
                                                  1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= 1'b0;
            bird_go_q    <= 1'b0;
            pipe_go_q    <= 1'b0;
            bird_erase_q <= 1'b0;
            pipe_erase_q <= 1'b0;
            busy_q       <= 1'b0;
            missed_q     <= '0;
            fault_q      <= 1'b0;
`ifdef FRAME_PEND_EN
            pend_q       <= 1'b0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            step_q    <= 1'b0;
            bird_go_q <= 1'b0;
            pipe_go_q <= 1'b0;

            if (count_miss_d && (missed_q != 8'hFF)) begin
                missed_q <= missed_q + 8'd1;
            end
`ifdef FRAME_PEND_EN
            pend_q <= pend_d;
`endif
            if (timeout_d) begin
                fault_q <= 1'b1;
            end

            if (advance_d) begin
                state_q      <= next_state_d;
                cnt_q        <= '0;
                // Outputs are decoded from the state being entered so they line up with it.
                step_q       <= (next_state_d == S_STEP);
                pipe_go_q    <= (next_state_d == S_ERASE_PIPE) || (next_state_d == S_DRAW_PIPE);
                bird_go_q    <= (next_state_d == S_ERASE_BIRD) || (next_state_d == S_DRAW_BIRD);
                pipe_erase_q <= (next_state_d == S_ERASE_PIPE);
                bird_erase_q <= (next_state_d == S_ERASE_BIRD);
                busy_q       <= (next_state_d != S_IDLE);
            end else if (drawer_phase_d) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // VGA arbitration: purely a function of state, so reset blanks it at once.
    logic [X_W-1:0] vga_x_d;
    logic [Y_W-1:0] vga_y_d;
    logic [C_W-1:0] vga_colour_d;
    logic           vga_plot_d;

    always_comb begin
        vga_x_d      = '0;
        vga_y_d      = '0;
        vga_colour_d = '0;
        vga_plot_d   = 1'b0;
        case (state_q)
            S_ERASE_PIPE, S_DRAW_PIPE: begin
                vga_x_d      = fs.pipe_x;
                vga_y_d      = fs.pipe_y;
                vga_plot_d   = fs.pipe_plot;
                vga_colour_d = (state_q == S_ERASE_PIPE) ? ERASE_COLOUR : fs.pipe_colour;
            end
            S_ERASE_BIRD, S_DRAW_BIRD: begin
                vga_x_d      = fs.bird_x;
                vga_y_d      = fs.bird_y;
                vga_plot_d   = fs.bird_plot;
                vga_colour_d = (state_q == S_ERASE_BIRD) ? ERASE_COLOUR : fs.bird_colour;
            end
            default: ;
        endcase
    end

    assign fs.step          = step_q;
    assign fs.bird_go       = bird_go_q;
    assign fs.pipe_go       = pipe_go_q;
    assign fs.bird_erase    = bird_erase_q;
    assign fs.pipe_erase    = pipe_erase_q;
    assign fs.busy          = busy_q;
    assign fs.missed_frames = missed_q;
    assign fs.fault         = fault_q;
    assign fs.vga_x         = vga_x_d;
    assign fs.vga_y         = vga_y_d;
    assign fs.vga_colour    = vga_colour_d;
    assign fs.vga_plot      = vga_plot_d;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Directed bench for frame_scheduler (TIMEOUT=16, ERASE_COLOUR=3'b010).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Honours FRAME_PEND_EN for the expected missed-frame counts.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;
    localparam logic [2:0] ERASE_C = 3'b010;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    frame_scheduler_if #(.X_W(8), .Y_W(7), .C_W(3)) fs ();

    frame_scheduler #(
        .X_W(8), .Y_W(7), .C_W(3),
        .ERASE_COLOUR(ERASE_C),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .fs(fs)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        fs.frame_tick = 1'b1;
        clk_step();
        fs.frame_tick = 1'b0;
    endtask

    // Called in the go cycle; returns done in the second cycle, ends in next phase.
    task automatic finish_phase(input bit bird);
        clk_step();
        if (bird) fs.bird_done = 1'b1;
        else      fs.pipe_done = 1'b1;
        clk_step();
        fs.bird_done = 1'b0;
        fs.pipe_done = 1'b0;
    endtask

    task automatic run_frame();
        start_frame();
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        finish_phase(1'b0);
        finish_phase(1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got=%b exp=0", fs.busy); end
        checks++; if ({fs.step, fs.bird_go, fs.pipe_go, fs.bird_erase, fs.pipe_erase} !== 5'b0) begin
            failures++; $display("FAIL rst_ctrl: got=%b exp=00000", {fs.step, fs.bird_go, fs.pipe_go, fs.bird_erase, fs.pipe_erase}); end
        checks++; if (fs.missed_frames !== 8'd0) begin failures++; $display("FAIL rst_missed: got=%0d exp=0", fs.missed_frames); end
        checks++; if (fs.fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got=%b exp=0", fs.fault); end
        checks++; if ({fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour} !== 19'd0) begin
            failures++; $display("FAIL rst_vga: got=%h exp=0", {fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour}); end
        @(negedge clk);
        resetn = 1'b1;
        clk_step();
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL rst_idle_no_tick: got=%b exp=0", fs.busy); end
    endtask

    task automatic test_frame();
        checks++; if (fs.pipe_go !== 1'b0) begin failures++; $display("FAIL frm_go_before_tick: got=%b exp=0", fs.pipe_go); end
        start_frame();
        // ERASE_PIPE cycle 1
        checks++; if ({fs.pipe_go, fs.pipe_erase, fs.bird_go, fs.busy} !== 4'b1101) begin
            failures++; $display("FAIL frm_ep1: got=%b exp=1101", {fs.pipe_go, fs.pipe_erase, fs.bird_go, fs.busy}); end
        clk_step();
        checks++; if ({fs.pipe_go, fs.pipe_erase} !== 2'b01) begin
            failures++; $display("FAIL frm_ep2: got=%b exp=01", {fs.pipe_go, fs.pipe_erase}); end
        fs.pipe_done = 1'b1;
        clk_step();
        fs.pipe_done = 1'b0;
        // ERASE_BIRD cycle 1
        checks++; if ({fs.bird_go, fs.bird_erase, fs.pipe_erase, fs.pipe_go} !== 4'b1100) begin
            failures++; $display("FAIL frm_eb1: got=%b exp=1100", {fs.bird_go, fs.bird_erase, fs.pipe_erase, fs.pipe_go}); end
        finish_phase(1'b1);
        // STEP
        checks++; if ({fs.step, fs.bird_go, fs.pipe_go, fs.bird_erase} !== 4'b1000) begin
            failures++; $display("FAIL frm_step: got=%b exp=1000", {fs.step, fs.bird_go, fs.pipe_go, fs.bird_erase}); end
        clk_step();
        // DRAW_PIPE cycle 1
        checks++; if ({fs.step, fs.pipe_go, fs.pipe_erase} !== 3'b010) begin
            failures++; $display("FAIL frm_dp1: got=%b exp=010", {fs.step, fs.pipe_go, fs.pipe_erase}); end
        finish_phase(1'b0);
        // DRAW_BIRD cycle 1
        checks++; if ({fs.bird_go, fs.bird_erase, fs.pipe_go} !== 3'b100) begin
            failures++; $display("FAIL frm_db1: got=%b exp=100", {fs.bird_go, fs.bird_erase, fs.pipe_go}); end
        clk_step();
        checks++; if (fs.busy !== 1'b1) begin failures++; $display("FAIL frm_db2_busy: got=%b exp=1", fs.busy); end
        fs.bird_done = 1'b1;
        clk_step();
        fs.bird_done = 1'b0;
        // 9 edges after the tick edge: back in IDLE
        checks++; if ({fs.busy, fs.fault, fs.bird_go} !== 3'b000) begin
            failures++; $display("FAIL frm_idle: got=%b exp=000", {fs.busy, fs.fault, fs.bird_go}); end
        checks++; if (fs.missed_frames !== 8'd0) begin failures++; $display("FAIL frm_missed: got=%0d exp=0", fs.missed_frames); end
    endtask

    task automatic test_mux();
        fs.pipe_x = 8'h11; fs.pipe_y = 7'h33; fs.pipe_colour = 3'b101; fs.pipe_plot = 1'b1;
        fs.bird_x = 8'h2A; fs.bird_y = 7'h15; fs.bird_colour = 3'b110; fs.bird_plot = 1'b1;
        #1;
        checks++; if ({fs.vga_plot, fs.vga_x, fs.vga_colour} !== 12'h000) begin
            failures++; $display("FAIL mux_idle: got=%h exp=000", {fs.vga_plot, fs.vga_x, fs.vga_colour}); end
        start_frame();
        checks++; if ({fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour} !== {1'b1, 8'h11, 7'h33, ERASE_C}) begin
            failures++; $display("FAIL mux_erase_pipe: got=%h exp=%h", {fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour}, {1'b1, 8'h11, 7'h33, ERASE_C}); end
        finish_phase(1'b0);
        checks++; if ({fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour} !== {1'b1, 8'h2A, 7'h15, ERASE_C}) begin
            failures++; $display("FAIL mux_erase_bird: got=%h exp=%h", {fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour}, {1'b1, 8'h2A, 7'h15, ERASE_C}); end
        fs.bird_plot = 1'b0;
        #1;
        checks++; if (fs.vga_plot !== 1'b0) begin failures++; $display("FAIL mux_inactive_plot: got=%b exp=0", fs.vga_plot); end
        fs.bird_plot = 1'b1;
        finish_phase(1'b1);
        checks++; if ({fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour} !== 19'd0) begin
            failures++; $display("FAIL mux_step: got=%h exp=0", {fs.vga_plot, fs.vga_x, fs.vga_y, fs.vga_colour}); end
        clk_step();
        checks++; if ({fs.vga_plot, fs.vga_x, fs.vga_colour} !== {1'b1, 8'h11, 3'b101}) begin
            failures++; $display("FAIL mux_draw_pipe: got=%h exp=%h", {fs.vga_plot, fs.vga_x, fs.vga_colour}, {1'b1, 8'h11, 3'b101}); end
        finish_phase(1'b0);
        checks++; if ({fs.vga_plot, fs.vga_y, fs.vga_colour} !== {1'b1, 7'h15, 3'b110}) begin
            failures++; $display("FAIL mux_draw_bird: got=%h exp=%h", {fs.vga_plot, fs.vga_y, fs.vga_colour}, {1'b1, 7'h15, 3'b110}); end
        finish_phase(1'b1);
        checks++; if (fs.vga_plot !== 1'b0) begin failures++; $display("FAIL mux_back_idle: got=%b exp=0", fs.vga_plot); end
    endtask

    task automatic test_missed();
        logic [7:0] exp_missed;
`ifdef FRAME_PEND_EN
        exp_missed = 8'd2;
`else
        exp_missed = 8'd3;
`endif
        start_frame();
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        // DRAW_PIPE held open while three ticks arrive
        for (int i = 0; i < 3; i++) begin
            clk_step();
            fs.frame_tick = 1'b1;
            clk_step();
            fs.frame_tick = 1'b0;
        end
        fs.pipe_done = 1'b1;
        clk_step();
        fs.pipe_done = 1'b0;
        finish_phase(1'b1);
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL miss_idle: got=%b exp=0", fs.busy); end
        checks++; if (fs.missed_frames !== exp_missed) begin
            failures++; $display("FAIL miss_count: got=%0d exp=%0d", fs.missed_frames, exp_missed); end
        clk_step();
`ifdef FRAME_PEND_EN
        checks++; if ({fs.pipe_go, fs.pipe_erase, fs.busy} !== 3'b111) begin
            failures++; $display("FAIL miss_pend_restart: got=%b exp=111", {fs.pipe_go, fs.pipe_erase, fs.busy}); end
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        finish_phase(1'b0);
        finish_phase(1'b1);
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL miss_pend_done: got=%b exp=0", fs.busy); end
`else
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL miss_no_restart: got=%b exp=0", fs.busy); end
`endif
        run_frame();
        checks++; if (fs.missed_frames !== exp_missed) begin
            failures++; $display("FAIL miss_idle_tick: got=%0d exp=%0d", fs.missed_frames, exp_missed); end
    endtask

    task automatic test_ignore();
        start_frame();
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        finish_phase(1'b0);
        // DRAW_BIRD go cycle: done here must be ignored
        fs.bird_done = 1'b1;
        clk_step();
        fs.bird_done = 1'b0;
        fs.pipe_done = 1'b1;
        checks++; if ({fs.busy, fs.vga_colour} !== {1'b1, 3'b110}) begin
            failures++; $display("FAIL ign_go_cycle_done: got=%b exp=1110", {fs.busy, fs.vga_colour}); end
        clk_step();
        fs.pipe_done = 1'b0;
        checks++; if ({fs.busy, fs.vga_colour} !== {1'b1, 3'b110}) begin
            failures++; $display("FAIL ign_pipe_done: got=%b exp=1110", {fs.busy, fs.vga_colour}); end
        fs.bird_done = 1'b1;
        clk_step();
        fs.bird_done = 1'b0;
        checks++; if ({fs.busy, fs.fault} !== 2'b00) begin
            failures++; $display("FAIL ign_late_done: got=%b exp=00", {fs.busy, fs.fault}); end
    endtask

    task automatic test_timeout();
        start_frame();
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        finish_phase(1'b0);
        // DRAW_BIRD entered; bird_done stays 0
        repeat (15) clk_step();
        checks++; if ({fs.busy, fs.fault} !== 2'b10) begin
            failures++; $display("FAIL to_before: got=%b exp=10", {fs.busy, fs.fault}); end
        clk_step();
        checks++; if ({fs.busy, fs.fault} !== 2'b01) begin
            failures++; $display("FAIL to_expire: got=%b exp=01", {fs.busy, fs.fault}); end
        run_frame();
        checks++; if ({fs.busy, fs.fault} !== 2'b01) begin
            failures++; $display("FAIL to_sticky: got=%b exp=01", {fs.busy, fs.fault}); end
    endtask

    task automatic test_saturate();
        fs.frame_tick = 1'b1;
        repeat (400) clk_step();
        fs.frame_tick = 1'b0;
        checks++; if (fs.missed_frames !== 8'd255) begin
            failures++; $display("FAIL sat_count: got=%0d exp=255", fs.missed_frames); end
        for (int i = 0; i < 200 && fs.busy === 1'b1; i++) clk_step();
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL sat_drain_timeout: got=%b exp=0", fs.busy); end
        checks++; if (fs.missed_frames !== 8'd255) begin
            failures++; $display("FAIL sat_hold: got=%0d exp=255", fs.missed_frames); end
    endtask

    task automatic test_reset_mid();
        start_frame();
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        // DRAW_PIPE go cycle, pipe_plot is 1 from the mux test
        checks++; if ({fs.pipe_go, fs.vga_plot} !== 2'b11) begin
            failures++; $display("FAIL rm_before: got=%b exp=11", {fs.pipe_go, fs.vga_plot}); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({fs.busy, fs.pipe_go, fs.vga_plot, fs.fault} !== 4'b0000) begin
            failures++; $display("FAIL rm_async: got=%b exp=0000", {fs.busy, fs.pipe_go, fs.vga_plot, fs.fault}); end
        checks++; if ({fs.missed_frames, fs.vga_colour, fs.vga_x} !== 19'd0) begin
            failures++; $display("FAIL rm_async_data: got=%h exp=0", {fs.missed_frames, fs.vga_colour, fs.vga_x}); end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        clk_step();
        fs.pipe_done = 1'b1;
        clk_step();
        fs.pipe_done = 1'b0;
        checks++; if (fs.busy !== 1'b0) begin failures++; $display("FAIL rm_no_wait: got=%b exp=0", fs.busy); end
        start_frame();
        checks++; if ({fs.pipe_go, fs.pipe_erase, fs.bird_go} !== 3'b110) begin
            failures++; $display("FAIL rm_restart: got=%b exp=110", {fs.pipe_go, fs.pipe_erase, fs.bird_go}); end
        finish_phase(1'b0);
        finish_phase(1'b1);
        clk_step();
        finish_phase(1'b0);
        finish_phase(1'b1);
        checks++; if ({fs.busy, fs.fault, fs.missed_frames} !== 10'd0) begin
            failures++; $display("FAIL rm_frame_done: got=%h exp=0", {fs.busy, fs.fault, fs.missed_frames}); end
    endtask

    initial begin
        resetn         = 1'b0;
        fs.frame_tick  = 1'b0;
        fs.bird_done   = 1'b0;
        fs.pipe_done   = 1'b0;
        fs.bird_x      = '0;
        fs.bird_y      = '0;
        fs.bird_colour = '0;
        fs.bird_plot   = 1'b0;
        fs.pipe_x      = '0;
        fs.pipe_y      = '0;
        fs.pipe_colour = '0;
        fs.pipe_plot   = 1'b0;

        test_reset();
        test_frame();
        test_mux();
        test_missed();
        test_ignore();
        test_timeout();
        test_saturate();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Per-frame sequencer and VGA write-port arbiter for the game screen.
- On each frame tick it runs a fixed phase order: erase pipes, erase bird, step the game state, draw pipes, draw bird.
- Starts the bird and pipe drawers with a go/done handshake and muxes the active drawer's pixel stream onto the single VGA plot port.
- Sits between the rate divider and the bird/pipe drawing datapaths, above the bird control FSM.

Parameters:
- X_W, 8, pixel x width
- Y_W, 7, pixel y width
- C_W, 3, colour width
- ERASE_COLOUR, 0, colour forced onto vga_colour during erase phases
- TIMEOUT, 20000, maximum cycles a phase waits for done (>=2)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle frame pulse from rate divider
- step  out  1  one-cycle pulse advancing bird/pipe positions
- bird_go  out  1  one-cycle start to bird drawer
- bird_erase  out  1  level, high while the bird phase is an erase
- bird_done  in  1  bird drawer finished (pulse or level)
- bird_x / bird_y / bird_colour / bird_plot  in  X_W / Y_W / C_W / 1  bird pixel stream
- pipe_go, pipe_erase, pipe_done, pipe_x, pipe_y, pipe_colour, pipe_plot  same as bird_*, for pipes
- vga_x / vga_y / vga_colour / vga_plot  out  X_W / Y_W / C_W / 1  arbitrated VGA write port
- busy  out  1  high in any state other than IDLE
- missed_frames  out  8  saturating count of dropped frame ticks
- fault  out  1  sticky, set on any phase timeout

Behaviour:
- States: IDLE -> ERASE_PIPE -> ERASE_BIRD -> STEP -> DRAW_PIPE -> DRAW_BIRD -> IDLE.
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All outputs 0, missed_frames=0, fault=0, timeout counter 0.
  - Reset mid-phase aborts immediately; no done is awaited afterwards.
- IDLE: frame_tick=1 -> ERASE_PIPE on the next edge.
- Drawer phases (ERASE_PIPE, ERASE_BIRD, DRAW_PIPE, DRAW_BIRD):
  - The matching *_go is high only in the first cycle of the phase.
  - *_erase is high for the whole of an erase phase.
  - The phase exits on the first edge where the matching *_done=1, sampled from the second phase cycle onward. A done in the go cycle is ignored.
- STEP lasts exactly one cycle with step=1, then goes to DRAW_PIPE.
- Done signals belonging to an inactive drawer are ignored.
- VGA mux (combinational from state):
  - In a drawer phase, vga_x, vga_y and vga_plot come from the active drawer.
  - vga_colour = ERASE_COLOUR in erase phases, otherwise the drawer colour.
  - In IDLE and STEP: vga_plot=0 and x/y/colour=0.
  - The inactive drawer's plot never reaches vga_plot.
- Timeout:
  - A per-phase counter clears on phase entry.
  - If done has not arrived when the count reaches TIMEOUT-1, the FSM advances to the next phase and fault is set.
  - fault stays set until reset.
- Latency:
  - frame_tick to pipe_go: 1 cycle.
  - Minimum frame is 1 + (4 x 2) + 1 = 10 cycles from tick back to IDLE, with done returned on the earliest legal cycle.
- Frame tick while busy=1 (this includes the final DRAW_BIRD cycle): missed_frames increments and saturates at 255.
- busy=0 only in IDLE. A frame_tick in IDLE is never counted as missed.

Optional Feature:
- FRAME_PEND_EN
- Defined:
  - A frame_tick during busy sets a one-deep pending flag instead of counting as missed.
  - When the FSM returns to IDLE with pending set, it goes straight to ERASE_PIPE on the next edge and clears pending.
  - Ticks arriving while pending is already set increment missed_frames.
  - A frame_tick in IDLE with pending set counts as missed.
- Undefined: no pending flag; every tick during busy increments missed_frames.

Test Plan:
- Reset, one frame_tick, drawers return done 1 cycle after go:
  - go pulses in order pipe(erase), bird(erase), step, pipe, bird.
  - step high exactly 1 cycle.
  - Back in IDLE 10 cycles after the tick; missed_frames=0, fault=0.
- During ERASE_BIRD, pipe_plot=1 with pipe_colour=3'b101 and bird_plot=1 with bird_colour=3'b110:
  - vga_plot=1 and vga_colour=ERASE_COLOUR, with x/y taken from bird.
  - In DRAW_BIRD, vga_colour=3'b110.
- Three extra ticks during a long DRAW_PIPE:
  - Macro off: missed_frames=3.
  - Macro on: missed_frames=2 and a new frame starts 1 cycle after IDLE.
- With TIMEOUT=16, bird_done held 0 in DRAW_BIRD:
  - Returns to IDLE 16 cycles after phase entry.
  - fault=1 and stays 1 through later frames.
- Assert resetn=0 mid DRAW_PIPE:
  - Outputs 0 immediately, without waiting for a clock edge.
  - After release, the next tick restarts at ERASE_PIPE.
- pipe_done pulse during DRAW_BIRD and bird_done in the go cycle:
  - Both ignored; the FSM stays in DRAW_BIRD until a later bird_done.
